bbc_io_responder: RTL and testbench

BBC_IO_RESPONDER -- requirements
Module: bbc_io_responder

---
 rtl/bbc_io_responder.sv | 189 ++++++++++++++++++
 tb/tb_bbc_io_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbc_io_responder.sv
`timescale 1ns/1ps
// BBC bus register window (DATA/STATUS/CONTROL) that bridges host accesses to a
// local TX byte FIFO and an RX holding register. Everything runs on hsclk.
module bbc_io_responder #(
  parameter logic [15:0] BASE_ADR = 16'hFE38,
  parameter int          TX_DEPTH = 8
) (
  input  logic        hsclk,
  input  logic        rst,
  input  logic        bbc_phi2,
  input  logic [15:0] bbc_adr,
  input  logic        bbc_rnw,
  input  logic [7:0]  bbc_data_in,
  output logic [7:0]  bbc_data_out,
  output logic        bbc_data_oe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_b
);
  localparam int AW = $clog2(TX_DEPTH);

  logic          phi2_s1_q, phi2_s1_d, phi2_s2_q, phi2_s2_d, phi2_s3_q, phi2_s3_d;
  logic [1:0]    init_q, init_d;
  logic          armed_q, armed_d, run_q, run_d;
  logic          sel_q, sel_d, rnw_q, rnw_d;
  logic [1:0]    off_q, off_d;
  logic [7:0]    rd_val_q, rd_val_d, wr_q, wr_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [7:0]    mem_d [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic          rx_ie_q, rx_ie_d, txe_ie_q, txe_ie_d;
  logic          irq_b_q, irq_b_d;

  logic       rise_det, fall_det, commit, win_match;
  logic       tx_empty, tx_full, tx_pop, push, push_ok, flush, rx_load, irq_cond;
  logic [7:0] status, rd_mux;

  // armed_q blocks a strobe that was already high when reset was released.
  assign rise_det  = phi2_s2_q & ~phi2_s3_q & armed_q;
  assign fall_det  = ~phi2_s2_q & phi2_s3_q;
  assign commit    = fall_det & sel_q;
  assign win_match = (bbc_adr[15:2] == BASE_ADR[15:2]);

  assign tx_empty = (tx_cnt_q == 4'd0);
  assign tx_full  = (tx_cnt_q == 4'(TX_DEPTH));
  assign tx_pop   = ~tx_empty & tx_ready;
  assign push     = commit & ~rnw_q & (off_q == 2'd0);
  assign push_ok  = push & ~tx_full;
  assign flush    = commit & ~rnw_q & (off_q == 2'd2) & wr_q[7];
  assign rx_load  = rx_valid & rx_ready;
  assign irq_cond = (rx_ie_q & rx_full_q) | (txe_ie_q & tx_empty);
  assign status   = {irq_cond, tx_cnt_q[2:0], tx_ovf_q, tx_empty, tx_full, rx_full_q};

  always_comb begin
    rd_mux = 8'h00;
    case (bbc_adr[1:0])
      2'd0:    rd_mux = rx_hold_q;
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {6'b0, txe_ie_q, rx_ie_q};
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    phi2_s1_d = bbc_phi2;
    phi2_s2_d = phi2_s1_q;
    phi2_s3_d = phi2_s2_q;
    init_d    = {init_q[0], 1'b1};
    armed_d   = armed_q | (init_q[1] & ~phi2_s2_q);
    run_d     = 1'b1;
    sel_d     = sel_q;
    rnw_d     = rnw_q;
    off_d     = off_q;
    rd_val_d  = rd_val_q;
    wr_d      = wr_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_hold_d = rx_hold_q;
    rx_ie_d   = rx_ie_q;
    txe_ie_d  = txe_ie_q;
    irq_b_d   = ~irq_cond;

    if (rise_det) begin
      sel_d    = win_match;
      off_d    = bbc_adr[1:0];
      rnw_d    = bbc_rnw;
      rd_val_d = rd_mux;
    end else if (fall_det) begin
      sel_d = 1'b0;
    end
    if (phi2_s2_q & sel_q & ~rnw_q) wr_d = bbc_data_in;

    // Flush overrides any local pop landing in the same cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      tx_cnt_d = 4'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wr_q;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (tx_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      tx_cnt_d = tx_cnt_q + {3'b0, push_ok} - {3'b0, tx_pop};
    end

    if (push & tx_full) tx_ovf_d = 1'b1;
    if (commit & rnw_q & (off_q == 2'd1)) tx_ovf_d = 1'b0;

    if (commit & ~rnw_q & (off_q == 2'd2)) begin
      rx_ie_d  = wr_q[0];
      txe_ie_d = wr_q[1];
    end

    if (commit & rnw_q & (off_q == 2'd0) & rx_full_q) rx_full_d = 1'b0;
    if (rx_load) begin
      rx_full_d = 1'b1;
      rx_hold_d = rx_data;
    end
  end

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      phi2_s1_q <= 1'b0;
      phi2_s2_q <= 1'b0;
      phi2_s3_q <= 1'b0;
      init_q    <= 2'b00;
      armed_q   <= 1'b0;
      run_q     <= 1'b0;
      sel_q     <= 1'b0;
      rnw_q     <= 1'b0;
      off_q     <= 2'd0;
      rd_val_q  <= 8'h00;
      wr_q      <= 8'h00;
      for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_cnt_q  <= 4'd0;
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= 8'h00;
      rx_ie_q   <= 1'b0;
      txe_ie_q  <= 1'b0;
      irq_b_q   <= 1'b1;
    end else begin
      phi2_s1_q <= phi2_s1_d;
      phi2_s2_q <= phi2_s2_d;
      phi2_s3_q <= phi2_s3_d;
      init_q    <= init_d;
      armed_q   <= armed_d;
      run_q     <= run_d;
      sel_q     <= sel_d;
      rnw_q     <= rnw_d;
      off_q     <= off_d;
      rd_val_q  <= rd_val_d;
      wr_q      <= wr_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
      rx_ie_q   <= rx_ie_d;
      txe_ie_q  <= txe_ie_d;
      irq_b_q   <= irq_b_d;
    end
  end

  // Drive enable follows the raw strobe so the bus is released as phi2 falls.
  assign bbc_data_oe  = bbc_phi2 & sel_q & rnw_q & ~rst;
  assign bbc_data_out = rd_val_q;
  assign tx_valid     = ~tx_empty;
  assign tx_data      = mem_q[rd_ptr_q];
  assign rx_ready     = ~rx_full_q & run_q;
  assign irq_b        = irq_b_q;
endmodule

// File: tb/tb_bbc_io_responder.sv
`timescale 1ns/1ps
// Bench for bbc_io_responder: directed scenarios then randomized BBC/local traffic
// compared against a queue-based model of the register map.
module tb_bbc_io_responder;
  localparam logic [15:0] BASE  = 16'hFE38;
  localparam int          DEPTH = 8;

  logic        hsclk = 1'b0;
  logic        rst;
  logic        bbc_phi2, bbc_rnw, bbc_data_oe, tx_valid, tx_ready, rx_valid, rx_ready, irq_b;
  logic [15:0] bbc_adr;
  logic [7:0]  bbc_data_in, bbc_data_out, tx_data, rx_data;

  bbc_io_responder #(.BASE_ADR(BASE), .TX_DEPTH(DEPTH)) dut (
    .hsclk(hsclk), .rst(rst), .bbc_phi2(bbc_phi2), .bbc_adr(bbc_adr), .bbc_rnw(bbc_rnw),
    .bbc_data_in(bbc_data_in), .bbc_data_out(bbc_data_out), .bbc_data_oe(bbc_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq_b(irq_b)
  );

  // Clock / reset
  always #31 hsclk = ~hsclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0] exp_q[$];
  logic       m_ovf, m_rx_full, m_rx_ie, m_txe_ie;
  logic [7:0] m_rx_hold;

  task automatic m_reset();
    exp_q.delete();
    m_ovf = 0; m_rx_full = 0; m_rx_ie = 0; m_txe_ie = 0; m_rx_hold = 8'h00;
  endtask

  function automatic logic m_irq();
    return (m_rx_ie && m_rx_full) || (m_txe_ie && exp_q.size() == 0);
  endfunction

  function automatic logic [7:0] m_status();
    logic [3:0] c;
    c = 4'(exp_q.size());
    return {m_irq(), c[2:0], m_ovf, exp_q.size() == 0, exp_q.size() == DEPTH, m_rx_full};
  endfunction

  function automatic logic in_win(input logic [15:0] adr);
    return adr[15:2] == BASE[15:2];
  endfunction

  // Driver tasks
  task automatic bbc_cycle(input logic [15:0] adr, input logic rnw, input logic [7:0] wd,
                           output logic [7:0] rd, output logic oe_hi, output logic oe_lo);
    @(negedge hsclk);
    bbc_adr = adr; bbc_rnw = rnw; bbc_data_in = rnw ? 8'($urandom) : wd;
    @(negedge hsclk);
    bbc_phi2 = 1'b1;
    repeat ($urandom_range(6, 9)) @(negedge hsclk);
    rd = bbc_data_out; oe_hi = bbc_data_oe;
    bbc_phi2 = 1'b0;
    #1 oe_lo = bbc_data_oe;
    repeat (6) @(negedge hsclk);
  endtask

  task automatic bbc_read(input logic [15:0] adr, output logic [7:0] rd);
    logic [7:0] exp;
    logic       oh, ol;
    case (adr[1:0])
      2'd0:    exp = m_rx_hold;
      2'd1:    exp = m_status();
      2'd2:    exp = {6'b0, m_txe_ie, m_rx_ie};
      default: exp = 8'h00;
    endcase
    bbc_cycle(adr, 1'b1, 8'h00, rd, oh, ol);
    if (in_win(adr)) begin
      check($sformatf("rd_data@%h", adr), rd, exp);
      check("rd_oe_during_phi2", oh, 1'b1);
      check("rd_oe_after_phi2", ol, 1'b0);
      if (adr[1:0] == 2'd0) m_rx_full = 0;
      if (adr[1:0] == 2'd1) m_ovf = 0;
    end else begin
      check("oe_outside_window", oh, 1'b0);
    end
  endtask

  task automatic bbc_write(input logic [15:0] adr, input logic [7:0] d);
    logic [7:0] rd;
    logic       oh, ol;
    bbc_cycle(adr, 1'b0, d, rd, oh, ol);
    check("wr_oe", oh | ol, 1'b0);
    if (in_win(adr)) begin
      if (adr[1:0] == 2'd0) begin
        if (exp_q.size() == DEPTH) m_ovf = 1;
        else exp_q.push_back(d);
      end else if (adr[1:0] == 2'd2) begin
        m_rx_ie = d[0]; m_txe_ie = d[1];
        if (d[7]) exp_q.delete();
      end
    end
  endtask

  task automatic settle_check(input string tag);
    check({tag, "_tx_valid"}, tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check({tag, "_tx_data"}, tx_data, exp_q[0]);
    check({tag, "_rx_ready"}, rx_ready, !m_rx_full);
    check({tag, "_irq_b"}, irq_b, !m_irq());
  endtask

  task automatic drain_all();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge hsclk);
      check("drain_valid", tx_valid, 1'b1);
      check("drain_data", tx_data, exp_q[0]);
      tx_ready = 1'b1;
      @(posedge hsclk);
      void'(exp_q.pop_front());
      budget--;
    end
    @(negedge hsclk);
    tx_ready = 1'b0;
    check("drain_done", exp_q.size(), 0);
    @(negedge hsclk);
  endtask

  task automatic local_cycles(input int n);
    logic irq_prev, r, v;
    logic [7:0] d;
    irq_prev = m_irq();
    for (int i = 0; i < n; i++) begin
      @(negedge hsclk);
      check("lc_tx_valid", tx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("lc_tx_data", tx_data, exp_q[0]);
      check("lc_rx_ready", rx_ready, !m_rx_full);
      check("lc_irq_b", irq_b, !irq_prev);
      irq_prev = m_irq();
      r = 1'($urandom_range(0, 1)); v = ($urandom_range(0, 3) == 0); d = 8'($urandom);
      tx_ready = r; rx_valid = v; rx_data = d;
      @(posedge hsclk);
      if (r && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && !m_rx_full) begin m_rx_full = 1; m_rx_hold = d; end
    end
    @(negedge hsclk);
    tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge hsclk);
  endtask

  task automatic reset_mid(input logic rnw);
    @(negedge hsclk);
    bbc_adr = BASE; bbc_rnw = rnw; bbc_data_in = 8'h77;
    @(negedge hsclk);
    bbc_phi2 = 1'b1;
    repeat (5) @(negedge hsclk);
    check("mid_oe_before_rst", bbc_data_oe, rnw);
    rst = 1'b1;
    #1 check("mid_oe_in_rst", bbc_data_oe, 1'b0);
    m_reset();
    repeat (2) @(negedge hsclk);
    rst = 1'b0;
    repeat (6) @(negedge hsclk);
    check("mid_oe_after_rst", bbc_data_oe, 1'b0);
    bbc_phi2 = 1'b0;
    repeat (6) @(negedge hsclk);
    settle_check("mid");
  endtask

  logic [7:0] rd;
  logic [15:0] adr;

  initial begin
    rst = 1'b1; bbc_phi2 = 0; bbc_adr = 16'h0000; bbc_rnw = 1; bbc_data_in = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    m_reset();
    repeat (3) @(negedge hsclk);
    check("rst_oe", bbc_data_oe, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_irq_b", irq_b, 1'b1);
    check("rst_data_out", bbc_data_out, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge hsclk);
    settle_check("post_rst");

    // Single write then STATUS
    bbc_write(BASE, 8'hA5);
    settle_check("a5");
    bbc_read(BASE + 16'd1, rd);
    check("a5_status_const", rd, 8'h10);
    drain_all();

    // Overflow: nine writes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) bbc_write(BASE, 8'(i));
    bbc_read(BASE + 16'd1, rd);
    check("ovf_status_const", rd, 8'h0A);
    bbc_read(BASE + 16'd1, rd);
    check("ovf_status2_const", rd, 8'h02);
    check("ovf_model_len", exp_q.size(), 8);
    drain_all();

    // RX byte with rx interrupt enabled
    @(negedge hsclk);
    check("rx_ready_pre", rx_ready, 1'b1);
    rx_valid = 1'b1; rx_data = 8'h3C;
    @(posedge hsclk);
    m_rx_full = 1; m_rx_hold = 8'h3C;
    @(negedge hsclk);
    rx_valid = 1'b0;
    bbc_write(BASE + 16'd2, 8'h01);
    repeat (2) @(negedge hsclk);
    check("rx_irq_b_low", irq_b, 1'b0);
    check("rx_ready_low", rx_ready, 1'b0);
    bbc_read(BASE, rd);
    check("rx_data_const", rd, 8'h3C);
    check("rx_irq_b_high", irq_b, 1'b1);
    check("rx_ready_high", rx_ready, 1'b1);
    bbc_write(BASE + 16'd2, 8'h00);

    // Flush with the local side draining, then with it stalled
    for (int i = 0; i < 4; i++) bbc_write(BASE, 8'($urandom));
    @(negedge hsclk);
    tx_ready = 1'b1;
    bbc_write(BASE + 16'd2, 8'h80);
    tx_ready = 1'b0;
    settle_check("flush1");
    for (int i = 0; i < 3; i++) bbc_write(BASE, 8'($urandom));
    bbc_write(BASE + 16'd2, 8'h80);
    settle_check("flush2");
    bbc_read(BASE + 16'd1, rd);
    check("flush_status_const", rd, 8'h04);
    bbc_read(BASE + 16'd2, rd);
    check("flush_ctrl_const", rd, 8'h00);

    // Outside the window
    bbc_write(BASE + 16'd1, 8'h11);
    bbc_write(16'hFE3C, 8'h55);
    bbc_read(16'hFE3C, rd);
    bbc_read(16'hFE30, rd);
    settle_check("outside");

    // Reset during an access
    reset_mid(1'b1);
    reset_mid(1'b0);
    bbc_write(BASE, 8'h5A);
    settle_check("after_mid");

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          adr = ($urandom_range(0, 7) == 0) ? 16'hFE3C + 16'($urandom_range(0, 3))
                                            : BASE + 16'($urandom_range(0, 3));
          if (adr[1:0] == 2'd2) bbc_write(adr, {($urandom_range(0, 5) == 0), 7'($urandom)});
          else bbc_write(adr, 8'($urandom));
        end
        3, 4: begin
          adr = ($urandom_range(0, 7) == 0) ? 16'hFE3C + 16'($urandom_range(0, 3))
                                            : BASE + 16'($urandom_range(0, 3));
          bbc_read(adr, rd);
        end
        default: local_cycles($urandom_range(1, 12));
      endcase
      settle_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
